// File: rtl/lcd_segment_ram.sv
// lcd_segment_ram: display segment memory for the 6S46 core.
// Holds 160 segment nibbles behind two CPU windows (0xE00-0xE4F lower,
// 0xE80-0xECF upper) plus the LCD control register at 0xF71, and streams
// the whole segment array to the video layer over a valid/ready handshake.
module lcd_segment_ram #(
   parameter int unsigned SEG_WORDS  = 160,
   parameter int unsigned HALF_WORDS = 80
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [11:0] memory_addr,
   input  logic        memory_write_en,
   input  logic [3:0]  memory_write_data,
   output logic        mem_hit,
   output logic [3:0]  memory_read_data,
   input  logic        frame_start,
   output logic        seg_valid,
   input  logic        seg_ready,
   output logic [7:0]  seg_index,
   output logic [3:0]  seg_data,
   output logic        frame_done,
   output logic        scan_busy
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      PRESENT
   } scan_state_t;

   localparam logic [7:0] LAST_IDX  = 8'(SEG_WORDS - 1);
   localparam logic [6:0] HALF_LIM  = 7'(HALF_WORDS);
   localparam logic [7:0] UPPER_OFS = 8'(HALF_WORDS);

   logic [3:0]  seg_mem [0:SEG_WORDS-1];
   logic [1:0]  ctrl;
   logic        lower_hit;
   logic        upper_hit;
   logic        ctrl_hit;
   logic        arr_hit;
   logic [7:0]  cpu_idx;

   scan_state_t state, state_nx;
   logic [7:0]  idx, idx_nx;
   logic        valid_nx;
   logic [7:0]  index_nx;
   logic [3:0]  data_nx;
   logic        done_nx;
   logic [3:0]  load_nibble;

   // Only ctrl bits [1:0] are stored; the upper write bits are discarded.
   logic unused_wdata_hi;
   assign unused_wdata_hi = ^memory_write_data[3:2];

   // Address decode of the two windows and the control register.
   always_comb begin
      lower_hit = (memory_addr[11:7] == 5'b11100) && (memory_addr[6:0] < HALF_LIM);
      upper_hit = (memory_addr[11:7] == 5'b11101) && (memory_addr[6:0] < HALF_LIM);
      ctrl_hit  = (memory_addr == 12'hF71);
      arr_hit   = lower_hit || upper_hit;
      cpu_idx   = upper_hit ? (UPPER_OFS + {1'b0, memory_addr[6:0]})
                            : {1'b0, memory_addr[6:0]};
   end

   assign mem_hit   = arr_hit || ctrl_hit;
   assign scan_busy = (state != IDLE);

   // Segment array CPU write port; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (arr_hit && memory_write_en) begin
         seg_mem[cpu_idx] <= memory_write_data;
      end
   end

   // Control register and registered CPU read data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl             <= '0;
         memory_read_data <= '0;
      end else begin
         if (ctrl_hit && memory_write_en) begin
            ctrl <= memory_write_data[1:0];
         end
         if (memory_write_en) begin
            memory_read_data <= '0;
         end else if (arr_hit) begin
            memory_read_data <= seg_mem[cpu_idx];
         end else if (ctrl_hit) begin
            memory_read_data <= {2'b00, ctrl};
         end else begin
            memory_read_data <= '0;
         end
      end
   end

   // Scan FSM state and registered scan outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         idx        <= '0;
         seg_valid  <= 1'b0;
         seg_index  <= '0;
         seg_data   <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         idx        <= idx_nx;
         seg_valid  <= valid_nx;
         seg_index  <= index_nx;
         seg_data   <= data_nx;
         frame_done <= done_nx;
      end
   end

   // Scan next-state logic; the array read here is the independent scan port,
   // and the control override is applied as the nibble is captured in LOAD.
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      valid_nx = seg_valid;
      index_nx = seg_index;
      data_nx  = seg_data;
      done_nx  = 1'b0;

      if (ctrl[1]) begin
         load_nibble = 4'h0;
      end else if (ctrl[0]) begin
         load_nibble = 4'hF;
      end else begin
         load_nibble = seg_mem[idx];
      end

      case (state)
         IDLE: begin
            if (frame_start) begin
               idx_nx   = '0;
               state_nx = LOAD;
            end
         end
         LOAD: begin
            data_nx  = load_nibble;
            index_nx = idx;
            valid_nx = 1'b1;
            state_nx = PRESENT;
         end
         PRESENT: begin
            if (seg_valid && seg_ready) begin
               valid_nx = 1'b0;
               if (idx == LAST_IDX) begin
                  done_nx  = 1'b1;
                  state_nx = IDLE;
               end else begin
                  idx_nx   = idx + 8'd1;
                  state_nx = LOAD;
               end
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_lcd_segment_ram.sv
// Directed self-checking bench for lcd_segment_ram.
module tb_lcd_segment_ram;

   logic        clk;
   logic        reset_n;
   logic [11:0] memory_addr;
   logic        memory_write_en;
   logic [3:0]  memory_write_data;
   logic        mem_hit;
   logic [3:0]  memory_read_data;
   logic        frame_start;
   logic        seg_valid;
   logic        seg_ready;
   logic [7:0]  seg_index;
   logic [3:0]  seg_data;
   logic        frame_done;
   logic        scan_busy;

   int total;
   int bad;

   lcd_segment_ram #(
      .SEG_WORDS  (160),
      .HALF_WORDS (80)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .memory_addr       (memory_addr),
      .memory_write_en   (memory_write_en),
      .memory_write_data (memory_write_data),
      .mem_hit           (mem_hit),
      .memory_read_data  (memory_read_data),
      .frame_start       (frame_start),
      .seg_valid         (seg_valid),
      .seg_ready         (seg_ready),
      .seg_index         (seg_index),
      .seg_data          (seg_data),
      .frame_done        (frame_done),
      .scan_busy         (scan_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and land just after the active edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [11:0] a, input logic [3:0] d);
      memory_addr       = a;
      memory_write_data = d;
      memory_write_en   = 1'b1;
      step();
      memory_write_en   = 1'b0;
   endtask

   function automatic logic [11:0] idx_addr(input int unsigned i);
      logic [11:0] a;
      if (i < 80) a = 12'hE00 + 12'(i);
      else        a = 12'hE80 + 12'(i - 80);
      return a;
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      total++;
      if ({seg_valid, seg_index, seg_data, frame_done, scan_busy, memory_read_data} !== 19'd0) begin
         bad++;
         $display("FAIL reset_outputs got valid=%b idx=%0d data=%h done=%b busy=%b rd=%h want all 0",
                  seg_valid, seg_index, seg_data, frame_done, scan_busy, memory_read_data);
      end
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_rw();
      cpu_write(12'hE05, 4'hA);
      total++;
      if (memory_read_data !== 4'h0) begin
         bad++;
         $display("FAIL write_cycle_rdata got %h want 0", memory_read_data);
      end
      cpu_write(12'hE85, 4'h5);
      memory_addr = 12'hE05;
      #1;
      total++;
      if (mem_hit !== 1'b1) begin bad++; $display("FAIL hit_E05 got %b want 1", mem_hit); end
      step();
      total++;
      if (memory_read_data !== 4'hA) begin bad++; $display("FAIL read_E05 got %h want a", memory_read_data); end
      memory_addr = 12'hE85;
      #1;
      total++;
      if (mem_hit !== 1'b1) begin bad++; $display("FAIL hit_E85 got %b want 1", mem_hit); end
      step();
      total++;
      if (memory_read_data !== 4'h5) begin bad++; $display("FAIL read_E85 got %h want 5", memory_read_data); end
      memory_addr = 12'h000;
      step();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 160; i++) begin
         logic [7:0] b;
         b = 8'(i);
         cpu_write(idx_addr(i), b[3:0]);
      end
   endtask

   task automatic test_unmapped();
      logic [11:0] addrs [3];
      addrs[0] = 12'hE50;
      addrs[1] = 12'hE7F;
      addrs[2] = 12'hED0;
      for (int k = 0; k < 3; k++) begin
         memory_addr = addrs[k];
         memory_write_en = 1'b0;
         #1;
         total++;
         if (mem_hit !== 1'b0) begin bad++; $display("FAIL unmapped_hit addr=%h got %b want 0", addrs[k], mem_hit); end
         step();
         total++;
         if (memory_read_data !== 4'h0) begin bad++; $display("FAIL unmapped_rd addr=%h got %h want 0", addrs[k], memory_read_data); end
      end
      memory_addr = 12'hE50;
      #1;
      total++;
      if (mem_hit !== 1'b0) begin bad++; $display("FAIL unmapped_wr_hit got %b want 0", mem_hit); end
      cpu_write(12'hE50, 4'hF);
      memory_addr = 12'h000;
   endtask

   // mode 0: nibble i[3:0]; mode 1: all 0; mode 2: all F.
   // restrike re-pulses frame_start mid-scan, which must be ignored.
   task automatic test_scan(input int mode, input bit restrike);
      int beats;
      int dones;
      bit fin;
      logic [7:0] b;
      logic [3:0] exp;
      beats = 0;
      dones = 0;
      fin = 1'b0;
      seg_ready = 1'b1;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      total++;
      if (scan_busy !== 1'b1) begin bad++; $display("FAIL scan_busy_start got %b want 1", scan_busy); end
      for (int c = 0; c < 1000 && !fin; c++) begin
         step();
         frame_start = restrike && (beats == 5);
         if (seg_valid) begin
            b = 8'(beats);
            exp = (mode == 1) ? 4'h0 : (mode == 2) ? 4'hF : b[3:0];
            total++;
            if (seg_index !== b) begin bad++; $display("FAIL scan_index got %0d want %0d", seg_index, beats); end
            total++;
            if (seg_data !== exp) begin bad++; $display("FAIL scan_data idx=%0d got %h want %h", beats, seg_data, exp); end
            beats++;
         end
         if (frame_done) begin
            dones++;
            fin = 1'b1;
            total++;
            if (beats !== 160) begin bad++; $display("FAIL scan_beats got %0d want 160", beats); end
            total++;
            if (scan_busy !== 1'b0) begin bad++; $display("FAIL busy_at_done got %b want 0", scan_busy); end
         end
      end
      frame_start = 1'b0;
      total++;
      if (!fin) begin bad++; $display("FAIL scan_timeout got beats=%0d want frame_done", beats); end
      step();
      total++;
      if (frame_done !== 1'b0 || scan_busy !== 1'b0) begin
         bad++;
         $display("FAIL done_single_pulse got done=%b busy=%b want 0 0", frame_done, scan_busy);
      end
   endtask

   task automatic test_backpressure();
      bit found;
      found = 1'b0;
      seg_ready = 1'b1;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         step();
         if (seg_valid && seg_index == 8'd10) found = 1'b1;
      end
      total++;
      if (!found) begin bad++; $display("FAIL bp_reach10 got none want index 10"); end
      seg_ready = 1'b0;
      memory_addr = 12'hE0A;
      memory_write_data = 4'h3;
      memory_write_en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         memory_write_en = 1'b0;
         total++;
         if (seg_valid !== 1'b1 || seg_index !== 8'd10 || seg_data !== 4'hA) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d got v=%b idx=%0d d=%h want 1 10 a", k, seg_valid, seg_index, seg_data);
         end
      end
      seg_ready = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         step();
         if (seg_valid) found = 1'b1;
      end
      total++;
      if (!found || seg_index !== 8'd11 || seg_data !== 4'hB) begin
         bad++;
         $display("FAIL bp_next got found=%b idx=%0d d=%h want 1 11 b", found, seg_index, seg_data);
      end
      found = 1'b0;
      for (int c = 0; c < 1000 && !found; c++) begin
         step();
         if (frame_done) found = 1'b1;
      end
      total++;
      if (!found) begin bad++; $display("FAIL bp_done got none want frame_done"); end
      memory_addr = 12'hE0A;
      #1;
      step();
      total++;
      if (memory_read_data !== 4'h3) begin bad++; $display("FAIL bp_write_landed got %h want 3", memory_read_data); end
      cpu_write(12'hE0A, 4'hA);
   endtask

   task automatic test_ctrl();
      cpu_write(12'hF71, 4'b0011);
      memory_addr = 12'hF71;
      #1;
      total++;
      if (mem_hit !== 1'b1) begin bad++; $display("FAIL ctrl_hit got %b want 1", mem_hit); end
      step();
      total++;
      if (memory_read_data !== 4'h3) begin bad++; $display("FAIL ctrl_read got %h want 3", memory_read_data); end
      test_scan(1, 1'b0);
      cpu_write(12'hF71, 4'b1101);
      memory_addr = 12'hF71;
      step();
      total++;
      if (memory_read_data !== 4'h1) begin bad++; $display("FAIL ctrl_read_masked got %h want 1", memory_read_data); end
      test_scan(2, 1'b0);
      cpu_write(12'hF71, 4'b0000);
   endtask

   task automatic test_reset_mid_scan();
      bit found;
      found = 1'b0;
      seg_ready = 1'b1;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      for (int c = 0; c < 500 && !found; c++) begin
         step();
         if (seg_valid && seg_index == 8'd40) found = 1'b1;
      end
      total++;
      if (!found) begin bad++; $display("FAIL rst_reach40 got none want index 40"); end
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if (seg_valid !== 1'b0 || scan_busy !== 1'b0 || seg_index !== 8'd0) begin
         bad++;
         $display("FAIL rst_async got v=%b busy=%b idx=%0d want 0 0 0", seg_valid, scan_busy, seg_index);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         total++;
         if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_no_done got %b want 0", frame_done); end
      end
      reset_n = 1'b1;
      step();
      test_scan(0, 1'b1);
   endtask

   initial begin
      total = 0;
      bad = 0;
      memory_addr = '0;
      memory_write_en = 1'b0;
      memory_write_data = '0;
      frame_start = 1'b0;
      seg_ready = 1'b0;
      reset_n = 1'b1;
      test_reset();
      test_rw();
      test_fill();
      test_unmapped();
      test_scan(0, 1'b0);
      test_backpressure();
      test_ctrl();
      test_reset_mid_scan();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
